// File: rtl/mult_types_pkg.sv
// Shared types for the add-shift multiplier and the arbiter that sequences jobs onto it.
package mult_types_pkg;

  localparam int width_p         = 8;
  localparam int num_req_default = 4;

  typedef logic [width_p-1:0]                 operand_t;
  typedef logic [2*width_p-1:0]               result_t;
  typedef logic [$clog2(num_req_default)-1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mult_arb_state_t;

endpackage

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin pick: first set request bit at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int num_req_p = 4
) (
  input  logic [num_req_p-1:0]         req_i,
  input  logic [$clog2(num_req_p)-1:0] ptr_i,
  output logic [num_req_p-1:0]         grant_o,
  output logic [$clog2(num_req_p)-1:0] idx_o,
  output logic                         valid_o
);

  localparam int idx_w = $clog2(num_req_p);

  logic [idx_w-1:0] cand;

  // Modulo wrap keeps the scan correct for requester counts that are not a power of two.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = idx_w'((int'(ptr_i) + i) % num_req_p);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (valid_o) begin
      grant_o = {{(num_req_p-1){1'b0}}, 1'b1} << idx_o;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one add_shift_multiplier among num_req_p requesters.
// Defining MULT_ARB_TIMEOUT_EN adds a WAIT watchdog and the resp_err_o flag.
module mult_arbiter
  import mult_types_pkg::*;
#(
  parameter int num_req_p = num_req_default
`ifdef MULT_ARB_TIMEOUT_EN
  , parameter int timeout_p = 2*width_p+8
`endif
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] req_valid_i,
  input  operand_t             req_multiplicand_i [num_req_p],
  input  operand_t             req_multiplier_i   [num_req_p],
  output logic [num_req_p-1:0] req_ready_o,
  output logic [num_req_p-1:0] resp_valid_o,
  input  logic [num_req_p-1:0] resp_ready_i,
  output result_t              resp_product_o,
  output logic                 mult_start_o,
  output operand_t             mult_multiplicand_o,
  output operand_t             mult_multiplier_o,
  input  logic                 mult_ready_i,
  input  logic                 mult_done_i,
  input  result_t              mult_product_i
`ifdef MULT_ARB_TIMEOUT_EN
  , output logic               resp_err_o
`endif
);

  localparam int idx_w = $clog2(num_req_p);

  mult_arb_state_t      state_q, state_d;
  logic [idx_w-1:0]     gnt_idx_q, gnt_idx_d;
  logic [idx_w-1:0]     ptr_q, ptr_d;
  logic [num_req_p-1:0] resp_valid_q, resp_valid_d;
  logic                 start_q, start_d;
  operand_t             mcand_q, mcand_d;
  operand_t             mplier_q, mplier_d;
  result_t              product_q, product_d;

  logic [num_req_p-1:0] arb_grant;
  logic [idx_w-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 take;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int tmo_w = $clog2(timeout_p+1);
  logic [tmo_w-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
`endif

  rr_arbiter #(
    .num_req_p(num_req_p)
  ) u_rr (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .grant_o(arb_grant),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  assign take        = (state_q == IDLE) && mult_ready_i && arb_valid;
  assign req_ready_o = take ? arb_grant : '0;

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    start_d      = 1'b0;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    product_d    = product_q;
`ifdef MULT_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (take) begin
          gnt_idx_d = arb_idx;
          mcand_d   = req_multiplicand_i[arb_idx];
          mplier_d  = req_multiplier_i[arb_idx];
          start_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (mult_done_i) begin
          product_d    = mult_product_i;
          resp_valid_d = {{(num_req_p-1){1'b0}}, 1'b1} << gnt_idx_q;
          state_d      = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d        = 1'b0;
        end else if (tmo_cnt_q == tmo_w'(timeout_p)) begin
          product_d    = '0;
          resp_valid_d = {{(num_req_p-1){1'b0}}, 1'b1} << gnt_idx_q;
          err_d        = 1'b1;
          state_d      = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        // Pointer moves only when the response completes, so a stalled requester keeps its turn.
        if (resp_ready_i[gnt_idx_q]) begin
          resp_valid_d = '0;
          ptr_d        = (gnt_idx_q == idx_w'(num_req_p-1)) ? '0 : gnt_idx_q + 1'b1;
          state_d      = IDLE;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      gnt_idx_q    <= '0;
      ptr_q        <= '0;
      resp_valid_q <= '0;
      start_q      <= 1'b0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      product_q    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      start_q      <= start_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      product_q    <= product_d;
`ifdef MULT_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign resp_valid_o        = resp_valid_q;
  assign resp_product_o      = product_q;
  assign mult_start_o        = start_q;
  assign mult_multiplicand_o = mcand_q;
  assign mult_multiplier_o   = mplier_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign resp_err_o          = err_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a cycle-accurate add-shift multiplier stand-in.
// Define MULT_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_mult_arbiter;
  import mult_types_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 2*width_p+8;

  typedef struct {
    int      idx;
    result_t prod;
    logic    err;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [NREQ-1:0] req_valid;
  operand_t        req_mcand  [NREQ];
  operand_t        req_mplier [NREQ];
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] resp_ready;
  result_t         resp_product;
  logic            mult_start;
  operand_t        mult_mcand;
  operand_t        mult_mplier;
  logic            mult_ready;
  logic            mult_done;
  result_t         mult_product;
`ifdef MULT_ARB_TIMEOUT_EN
  logic            resp_err;
`endif

  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  logic    stall = 1'b0;
  logic    m_busy;
  int      m_cnt;
  result_t m_prod;

  always #5 clk_i = ~clk_i;

  mult_arbiter #(.num_req_p(NREQ)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .req_valid_i        (req_valid),
    .req_multiplicand_i (req_mcand),
    .req_multiplier_i   (req_mplier),
    .req_ready_o        (req_ready),
    .resp_valid_o       (resp_valid),
    .resp_ready_i       (resp_ready),
    .resp_product_o     (resp_product),
    .mult_start_o       (mult_start),
    .mult_multiplicand_o(mult_mcand),
    .mult_multiplier_o  (mult_mplier),
    .mult_ready_i       (mult_ready),
    .mult_done_i        (mult_done),
    .mult_product_i     (mult_product)
`ifdef MULT_ARB_TIMEOUT_EN
    , .resp_err_o       (resp_err)
`endif
  );

  // Multiplier stand-in: done rises 16 cycles after the start cycle and clears when a new start is seen.
  always @(posedge clk_i) begin
    if (reset_i) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      mult_done  <= 1'b0;
      mult_ready <= 1'b1;
      m_prod     <= '0;
    end else if (mult_start) begin
      m_busy     <= 1'b1;
      m_cnt      <= 2*width_p-1;
      mult_done  <= 1'b0;
      mult_ready <= 1'b0;
      m_prod     <= result_t'(mult_mcand) * result_t'(mult_mplier);
    end else if (m_busy) begin
      if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (!stall) begin
        mult_done  <= 1'b1;
        mult_ready <= 1'b1;
        m_busy     <= 1'b0;
      end
    end
  end

  assign mult_product = mult_done ? m_prod : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (req_ready != '0) checkOutput("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
      if (resp_valid != '0) begin
        checkOutput("resp_valid_onehot", 32'($onehot(resp_valid)), 32'd1);
        if ((resp_valid & resp_ready) != '0) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
          end else begin
            exp_t e;
            int   got;
            e   = sb.pop_front();
            got = -1;
            for (int i = 0; i < NREQ; i++) if (resp_valid[i]) got = i;
            checkOutput("sb_requester", 32'(got), 32'(e.idx));
            checkOutput("sb_product", 32'(resp_product), 32'(e.prod));
`ifdef MULT_ARB_TIMEOUT_EN
            checkOutput("sb_err", 32'(resp_err), 32'(e.err));
`endif
          end
        end
      end
    end
  end

  task automatic doReset();
    @(posedge clk_i); #1;
    reset_i   = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || resp_valid != '0) && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic applyStimulus(input int idx, input operand_t a, input operand_t b,
                               input result_t exp, input string tag);
    int n = 0;
    @(posedge clk_i); #1;
    req_mcand[idx]  = a;
    req_mplier[idx] = b;
    req_valid[idx]  = 1'b1;
    sb.push_back('{idx, exp, 1'b0});
    do begin
      @(negedge clk_i);
      n++;
    end while (!req_ready[idx] && n < 100);
    checkOutput({tag, "_accept"}, 32'(req_ready), 32'(1 << idx));
    @(posedge clk_i); #1;
    req_valid[idx] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int lat;
    int acc;
    int n;
    reset_i    = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_mcand[i]  = '0;
      req_mplier[i] = '0;
    end
    doReset();

    @(negedge clk_i);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_start", 32'(mult_start), 32'd0);
    checkOutput("rst_product", 32'(resp_product), 32'd0);
    checkOutput("rst_mult_a", 32'(mult_mcand), 32'd0);
`ifdef MULT_ARB_TIMEOUT_EN
    checkOutput("rst_err", 32'(resp_err), 32'd0);
`endif

    // Single request with cycle-exact latency.
    @(posedge clk_i); #1;
    req_mcand[1]  = 8'h0D;
    req_mplier[1] = 8'h0B;
    req_valid     = 4'b0010;
    sb.push_back('{1, 16'h008F, 1'b0});
    @(negedge clk_i);
    checkOutput("t1_req_ready", 32'(req_ready), 32'h2);
    @(posedge clk_i); #1;
    req_valid = '0;
    @(negedge clk_i);
    checkOutput("t1_start", 32'(mult_start), 32'd1);
    checkOutput("t1_mult_a", 32'(mult_mcand), 32'h0D);
    checkOutput("t1_mult_b", 32'(mult_mplier), 32'h0B);
    lat = 1;
    while (resp_valid == '0 && lat < 60) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput("t1_latency", 32'(lat), 32'd18);
    checkOutput("t1_resp_valid", 32'(resp_valid), 32'h2);
    checkOutput("t1_product", 32'(resp_product), 32'h008F);
    waitDrain("t1");

    // Round robin from pointer 0 with everyone continuously valid.
    doReset();
    @(posedge clk_i); #1;
    for (int k = 0; k < NREQ; k++) begin
      req_mcand[k]  = operand_t'(k);
      req_mplier[k] = 8'h02;
    end
    sb.push_back('{0, 16'h0000, 1'b0});
    sb.push_back('{1, 16'h0002, 1'b0});
    sb.push_back('{2, 16'h0004, 1'b0});
    sb.push_back('{3, 16'h0006, 1'b0});
    sb.push_back('{0, 16'h0000, 1'b0});
    req_valid = '1;
    acc = 0;
    n   = 0;
    while (acc < 5 && n < 300) begin
      @(negedge clk_i);
      if (req_ready != '0) acc++;
      n++;
    end
    checkOutput("t2_accepts", 32'(acc), 32'd5);
    @(posedge clk_i); #1;
    req_valid = '0;
    waitDrain("t2");

    // Backpressure: product held, no new acceptance until the handshake.
    resp_ready = '0;
    applyStimulus(2, 8'h05, 8'h07, 16'h0023, "t3a");
    req_mcand[0]  = 8'h03;
    req_mplier[0] = 8'h04;
    req_valid[0]  = 1'b1;
    sb.push_back('{0, 16'h000C, 1'b0});
    n = 0;
    while (resp_valid == '0 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", 32'(resp_valid), 32'h4);
      checkOutput("t3_hold_product", 32'(resp_product), 32'h0023);
      checkOutput("t3_no_accept", 32'(req_ready), 32'd0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    resp_ready = '1;
    n = 0;
    while (!req_ready[0] && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("t3b_accept", 32'(req_ready), 32'h1);
    @(posedge clk_i); #1;
    req_valid[0] = 1'b0;
    waitDrain("t3");

    // Boundary operands.
    applyStimulus(3, 8'hFF, 8'hFF, 16'hFE01, "t4a");
    waitDrain("t4a");
    applyStimulus(0, 8'h00, 8'hA5, 16'h0000, "t4b");
    waitDrain("t4b");

    // Reset in cycle 6 abandons the job silently.
    @(posedge clk_i); #1;
    req_mcand[1]  = 8'h11;
    req_mplier[1] = 8'h22;
    req_valid     = 4'b0010;
    @(negedge clk_i);
    checkOutput("t5_accept", 32'(req_ready), 32'h2);
    @(posedge clk_i); #1;
    req_valid = '0;
    repeat (5) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t5_rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("t5_rst_start", 32'(mult_start), 32'd0);
    checkOutput("t5_rst_mult_a", 32'(mult_mcand), 32'd0);
    checkOutput("t5_rst_mult_b", 32'(mult_mplier), 32'd0);
    checkOutput("t5_rst_product", 32'(resp_product), 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (resp_valid != '0) n++;
    end
    checkOutput("t5_no_resp", 32'(n), 32'd0);
    applyStimulus(1, 8'h12, 8'h10, 16'h0120, "t5b");
    waitDrain("t5b");

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: multiplier never finishes.
    stall = 1'b1;
    @(posedge clk_i); #1;
    req_mcand[2]  = 8'h33;
    req_mplier[2] = 8'h44;
    req_valid     = 4'b0100;
    sb.push_back('{2, 16'h0000, 1'b1});
    @(negedge clk_i);
    checkOutput("t6_accept", 32'(req_ready), 32'h4);
    @(posedge clk_i); #1;
    req_valid = '0;
    @(negedge clk_i);
    lat = 1;
    while (resp_valid == '0 && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput("t6_latency", 32'(lat), 32'(2 + TIMEOUT + 1));
    checkOutput("t6_err", 32'(resp_err), 32'd1);
    checkOutput("t6_product", 32'(resp_product), 32'd0);
    waitDrain("t6");
    stall = 1'b0;
    doReset();
`endif

    repeat (3) @(posedge clk_i);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
